// File: rtl/mmcm_multi_phaseshift_pkg.sv
// Shared definitions for the multi-channel MMCM fine phase-shift controller:
// FSM encoding, step-direction constants and the PSDONE timeout counter width.
package mmcm_multi_phaseshift_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_CHECK = 2'd3
   } ps_state_e;

   localparam logic PS_INC = 1'b1;
   localparam logic PS_DEC = 1'b0;

   // Counter must be able to hold the value TIMEOUT itself.
   function automatic int tmo_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mmcm_ps_channel.sv
// One MMCM dynamic phase-shift channel: walks the current phase toward the
// requested one a single PSEN step at a time, always along the shorter arc.
module mmcm_ps_channel
   import mmcm_multi_phaseshift_pkg::*;
#(
   parameter int PW            = 9,
   parameter int PHASE_MOD     = 448,
   parameter int DEFAULT_PHASE = 0,
   parameter int TIMEOUT       = 255
) (
   input  logic          clk_usb,
   input  logic          reset_i,
   input  logic [PW-1:0] target_i,
   input  logic          load_i,
   input  logic          mmcm_locked_i,
   input  logic          psdone_i,
   output logic [PW-1:0] actual_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          psen_o,
   output logic          psincdec_o
);

   localparam int PW1 = PW + 1;
   localparam int TW  = tmo_width(TIMEOUT);

   localparam logic [PW:0]   L_MOD  = PW1'(PHASE_MOD);
   localparam logic [PW:0]   L_HALF = PW1'(PHASE_MOD / 2);
   localparam logic [PW-1:0] L_LAST = PW'(PHASE_MOD - 1);
   localparam logic [PW-1:0] L_DEF  = PW'(DEFAULT_PHASE);
   localparam logic [TW-1:0] L_TMO  = TW'(TIMEOUT);

   ps_state_e     r_state;
   logic [PW-1:0] r_actual;
   logic [PW-1:0] r_target;
   logic [TW-1:0] r_tmo;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic          r_psen;
   logic          r_psincdec;

   logic          w_in_range;
   logic          w_load_ok;
   logic [PW:0]   w_tgt_ext;
   logic [PW:0]   w_act_ext;
   logic [PW:0]   w_dist;
   logic          w_dir;
   logic [PW-1:0] w_act_inc;
   logic [PW-1:0] w_act_dec;
   logic [PW-1:0] w_next_target;

   assign w_in_range = ({1'b0, target_i} < L_MOD);
   assign w_load_ok  = load_i & w_in_range;

   // Forward distance (target - actual) mod PHASE_MOD; the extra bit keeps
   // target + PHASE_MOD from overflowing when PHASE_MOD == 2**PW.
   assign w_tgt_ext = {1'b0, r_target};
   assign w_act_ext = {1'b0, r_actual};
   assign w_dist    = (w_tgt_ext >= w_act_ext) ? (w_tgt_ext - w_act_ext)
                                               : (w_tgt_ext + L_MOD - w_act_ext);
   assign w_dir     = (w_dist <= L_HALF) ? PS_INC : PS_DEC;

   assign w_act_inc = (r_actual == L_LAST) ? '0 : (r_actual + PW'(1));
   assign w_act_dec = (r_actual == '0) ? L_LAST : (r_actual - PW'(1));

   // A load landing in CHECK must be compared instead of the stale target.
   assign w_next_target = w_load_ok ? target_i : r_target;

   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         r_state    <= ST_IDLE;
         r_actual   <= L_DEF;
         r_target   <= L_DEF;
         r_tmo      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_psen     <= 1'b0;
         r_psincdec <= 1'b0;
      end else if (!mmcm_locked_i) begin
         // The MMCM restarts at its configured phase, so follow it; err is kept.
         r_state    <= ST_IDLE;
         r_actual   <= L_DEF;
         r_target   <= L_DEF;
         r_tmo      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_psen     <= 1'b0;
         r_psincdec <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_psen <= 1'b0;

         if (w_load_ok) begin
            r_target <= target_i;
            r_err    <= 1'b0;
         end else if (load_i) begin
            r_err <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_load_ok) begin
                  if (target_i == r_actual) begin
                     r_done <= 1'b1;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               r_psen     <= 1'b1;
               r_psincdec <= w_dir;
               r_tmo      <= '0;
               r_state    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (psdone_i) begin
                  r_actual <= (r_psincdec == PS_INC) ? w_act_inc : w_act_dec;
                  r_state  <= ST_CHECK;
               end else if (r_tmo == L_TMO) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end

            ST_CHECK: begin
               if (r_actual == w_next_target) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_ISSUE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign actual_o   = r_actual;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign err_o      = r_err;
   assign psen_o     = r_psen;
   assign psincdec_o = r_psincdec;

endmodule

// File: rtl/mmcm_multi_phaseshift.sv
// N-channel MMCM fine phase-shift controller: independent per-channel
// engines with packed per-channel buses toward the register block.
module mmcm_multi_phaseshift
   import mmcm_multi_phaseshift_pkg::*;
#(
   parameter int NCH           = 2,
   parameter int PW            = 9,
   parameter int PHASE_MOD     = 448,
   parameter int DEFAULT_PHASE = 0,
   parameter int TIMEOUT       = 255
) (
   input  logic              clk_usb,
   input  logic              reset_i,
   input  logic [NCH*PW-1:0] target_i,
   input  logic [NCH-1:0]    load_i,
   output logic [NCH*PW-1:0] actual_o,
   output logic [NCH-1:0]    busy_o,
   output logic [NCH-1:0]    done_o,
   output logic [NCH-1:0]    err_o,
   input  logic [NCH-1:0]    mmcm_locked_i,
   output logic [NCH-1:0]    psen_o,
   output logic [NCH-1:0]    psincdec_o,
   input  logic [NCH-1:0]    psdone_i
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      mmcm_ps_channel #(
         .PW            (PW),
         .PHASE_MOD     (PHASE_MOD),
         .DEFAULT_PHASE (DEFAULT_PHASE),
         .TIMEOUT       (TIMEOUT)
      ) u_ch (
         .clk_usb       (clk_usb),
         .reset_i       (reset_i),
         .target_i      (target_i[gi*PW +: PW]),
         .load_i        (load_i[gi]),
         .mmcm_locked_i (mmcm_locked_i[gi]),
         .psdone_i      (psdone_i[gi]),
         .actual_o      (actual_o[gi*PW +: PW]),
         .busy_o        (busy_o[gi]),
         .done_o        (done_o[gi]),
         .err_o         (err_o[gi]),
         .psen_o        (psen_o[gi]),
         .psincdec_o    (psincdec_o[gi])
      );
   end

endmodule
